// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, scoreboard and register-file write-port signals shared by the
// EXU/LSU writeback arbiter and whoever drives it.
interface regfile_wb_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                       flush;
   logic                       exu_valid;
   logic                       exu_ready;
   logic [ADDR_WIDTH-1:0]      exu_addr;
   logic [DATA_WIDTH-1:0]      exu_data;
   logic                       lsu_valid;
   logic                       lsu_ready;
   logic [ADDR_WIDTH-1:0]      lsu_addr;
   logic [DATA_WIDTH-1:0]      lsu_data;
   logic                       rf_wen;
   logic [ADDR_WIDTH-1:0]      rf_waddr;
   logic [DATA_WIDTH-1:0]      rf_wdata;
   logic                       rsv_valid;
   logic [ADDR_WIDTH-1:0]      rsv_addr;
   logic [ADDR_WIDTH-1:0]      chk_addr1;
   logic [ADDR_WIDTH-1:0]      chk_addr2;
   logic                       hazard;
   logic [2**ADDR_WIDTH-1:0]   busy_vec;

   modport slave (
      input  flush, exu_valid, exu_addr, exu_data, lsu_valid, lsu_addr, lsu_data,
             rsv_valid, rsv_addr, chk_addr1, chk_addr2,
      output exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, hazard, busy_vec
   );

   modport master (
      output flush, exu_valid, exu_addr, exu_data, lsu_valid, lsu_addr, lsu_data,
             rsv_valid, rsv_addr, chk_addr1, chk_addr2,
      input  exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, hazard, busy_vec
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between EXU and LSU writeback slots and
// tracks pending destinations for decode. REGFILE_ARB_RR_EN selects round-robin.
module regfile_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input logic                i_clk,
   input logic                i_rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int NumRegs = 2**ADDR_WIDTH;

   logic                  r_exu_full;
   logic [ADDR_WIDTH-1:0] r_exu_addr;
   logic [DATA_WIDTH-1:0] r_exu_data;
   logic                  r_lsu_full;
   logic [ADDR_WIDTH-1:0] r_lsu_addr;
   logic [DATA_WIDTH-1:0] r_lsu_data;
   logic [NumRegs-1:0]    r_busy;
   logic [NumRegs-1:0]    w_busy_d;

   logic                  w_exu_gnt;
   logic                  w_lsu_gnt;
   logic                  w_wen;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_exu_ready;
   logic                  w_lsu_ready;
   logic                  w_exu_acc;
   logic                  w_lsu_acc;

`ifdef REGFILE_ARB_RR_EN
   logic                  r_rr_ptr;
`endif

   always_comb begin
      w_exu_gnt = 1'b0;
      w_lsu_gnt = 1'b0;
      if (!bus.flush) begin
         if (r_exu_full && r_lsu_full) begin
`ifdef REGFILE_ARB_RR_EN
            w_exu_gnt = !r_rr_ptr;
            w_lsu_gnt = r_rr_ptr;
`else
            w_lsu_gnt = 1'b1;
`endif
         end else begin
            w_exu_gnt = r_exu_full;
            w_lsu_gnt = r_lsu_full;
         end
      end
   end

   always_comb begin
      w_wen   = w_exu_gnt || w_lsu_gnt;
      w_waddr = '0;
      w_wdata = '0;
      if (w_lsu_gnt) begin
         w_waddr = r_lsu_addr;
         w_wdata = r_lsu_data;
      end else if (w_exu_gnt) begin
         w_waddr = r_exu_addr;
         w_wdata = r_exu_data;
      end
   end

   // Ready is gated by rst so nothing is offered while the slots are held in reset.
   assign w_exu_ready = !i_rst && !bus.flush && (!r_exu_full || w_exu_gnt);
   assign w_lsu_ready = !i_rst && !bus.flush && (!r_lsu_full || w_lsu_gnt);
   assign w_exu_acc   = bus.exu_valid && w_exu_ready;
   assign w_lsu_acc   = bus.lsu_valid && w_lsu_ready;

   always_comb begin
      w_busy_d = r_busy;
      if (w_wen) begin
         w_busy_d[w_waddr] = 1'b0;
      end
      // Set after clear: a same-cycle reservation is younger than the retiring write.
      if (bus.rsv_valid && (bus.rsv_addr != '0) && !bus.flush) begin
         w_busy_d[bus.rsv_addr] = 1'b1;
      end
      if (bus.flush) begin
         w_busy_d = '0;
      end
      w_busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_exu_full <= 1'b0;
         r_exu_addr <= '0;
         r_exu_data <= '0;
      end else if (bus.flush) begin
         r_exu_full <= 1'b0;
      end else if (w_exu_acc) begin
         r_exu_full <= (bus.exu_addr != '0);
         r_exu_addr <= bus.exu_addr;
         r_exu_data <= bus.exu_data;
      end else if (w_exu_gnt) begin
         r_exu_full <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lsu_full <= 1'b0;
         r_lsu_addr <= '0;
         r_lsu_data <= '0;
      end else if (bus.flush) begin
         r_lsu_full <= 1'b0;
      end else if (w_lsu_acc) begin
         r_lsu_full <= (bus.lsu_addr != '0);
         r_lsu_addr <= bus.lsu_addr;
         r_lsu_data <= bus.lsu_data;
      end else if (w_lsu_gnt) begin
         r_lsu_full <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_d;
      end
   end

`ifdef REGFILE_ARB_RR_EN
   // After a contended grant the pointer moves to the loser.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr <= 1'b0;
      end else if (r_exu_full && r_lsu_full && w_wen) begin
         r_rr_ptr <= w_exu_gnt;
      end
   end
`endif

   assign bus.exu_ready = w_exu_ready;
   assign bus.lsu_ready = w_lsu_ready;
   assign bus.rf_wen    = w_wen;
   assign bus.rf_waddr  = w_waddr;
   assign bus.rf_wdata  = w_wdata;
   assign bus.busy_vec  = r_busy;
   assign bus.hazard    = ((bus.chk_addr1 != '0) && r_busy[bus.chk_addr1]) ||
                          ((bus.chk_addr2 != '0) && r_busy[bus.chk_addr2]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued at accept
// time and retired against rf_wen in a negedge monitor.
module tb_regfile_wb_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [AW+DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rf_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_wen", {59'd0, bus.rf_waddr}, 64'd0);
         end else begin
            logic [AW+DW-1:0] item;
            item = exp_q.pop_front();
            check("wb_addr", {59'd0, bus.rf_waddr}, {59'd0, item[AW+DW-1:DW]});
            check("wb_data", {32'd0, bus.rf_wdata}, {32'd0, item[DW-1:0]});
         end
      end
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bus.flush = 1'b0;
      bus.exu_valid = 1'b1;
      bus.exu_addr = 5'd5;
      bus.exu_data = 32'h1234;
      bus.lsu_valid = 1'b0;
      bus.lsu_addr = '0;
      bus.lsu_data = '0;
      bus.rsv_valid = 1'b0;
      bus.rsv_addr = '0;
      bus.chk_addr1 = '0;
      bus.chk_addr2 = '0;

      // Reset held with a pending EXU request
      repeat (2) @(posedge clk);
      sample();
      check("rst_wen", {63'd0, bus.rf_wen}, 64'd0);
      check("rst_waddr", {59'd0, bus.rf_waddr}, 64'd0);
      check("rst_wdata", {32'd0, bus.rf_wdata}, 64'd0);
      check("rst_busy", {32'd0, bus.busy_vec}, 64'd0);
      check("rst_exu_ready", {63'd0, bus.exu_ready}, 64'd0);
      check("rst_hazard", {63'd0, bus.hazard}, 64'd0);
      step();
      rst = 1'b0;
      bus.exu_valid = 1'b0;
      bus.exu_addr = '0;
      sample();
      check("post_rst_exu_ready", {63'd0, bus.exu_ready}, 64'd1);
      check("post_rst_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
      step();

      // Single write with reservation
      bus.rsv_valid = 1'b1;
      bus.rsv_addr = 5'd3;
      bus.chk_addr1 = 5'd3;
      step();
      bus.rsv_valid = 1'b0;
      bus.exu_valid = 1'b1;
      bus.exu_addr = 5'd3;
      bus.exu_data = 32'hDEADBEEF;
      sample();
      check("sw_hazard_pre", {63'd0, bus.hazard}, 64'd1);
      check("sw_exu_ready", {63'd0, bus.exu_ready}, 64'd1);
      expect_write(5'd3, 32'hDEADBEEF);
      step();
      bus.exu_valid = 1'b0;
      sample();
      check("sw_wen", {63'd0, bus.rf_wen}, 64'd1);
      check("sw_hazard_during", {63'd0, bus.hazard}, 64'd1);
      step();
      sample();
      check("sw_hazard_after", {63'd0, bus.hazard}, 64'd0);
      check("sw_busy_after", {32'd0, bus.busy_vec}, 64'd0);
      bus.chk_addr1 = '0;
      step();

      // Contention
      bus.exu_valid = 1'b1;
      bus.exu_addr = 5'd1;
      bus.exu_data = 32'h11;
      bus.lsu_valid = 1'b1;
      bus.lsu_addr = 5'd2;
      bus.lsu_data = 32'h22;
`ifdef REGFILE_ARB_RR_EN
      expect_write(5'd1, 32'h11);
      expect_write(5'd2, 32'h22);
`else
      expect_write(5'd2, 32'h22);
      expect_write(5'd1, 32'h11);
`endif
      step();
      bus.exu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      sample();
      check("ct_wen1", {63'd0, bus.rf_wen}, 64'd1);
`ifdef REGFILE_ARB_RR_EN
      check("ct_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
      check("ct_exu_ready", {63'd0, bus.exu_ready}, 64'd1);
`else
      check("ct_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
      check("ct_exu_ready", {63'd0, bus.exu_ready}, 64'd0);
`endif
      step();
      sample();
      check("ct_wen2", {63'd0, bus.rf_wen}, 64'd1);
      step();
      sample();
      check("ct_idle", {63'd0, bus.rf_wen}, 64'd0);
      step();

      // x0 drop
      bus.lsu_valid = 1'b1;
      bus.lsu_addr = 5'd0;
      bus.lsu_data = 32'h55;
      sample();
      check("x0_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
      step();
      bus.lsu_valid = 1'b0;
      sample();
      check("x0_no_wen", {63'd0, bus.rf_wen}, 64'd0);
      check("x0_busy", {32'd0, bus.busy_vec}, 64'd0);
      step();

      // Back-to-back EXU stream, one write per cycle
      for (int i = 0; i < 6; i++) begin
         a = AW'($urandom_range(1, 31));
         d = $urandom;
         bus.exu_valid = 1'b1;
         bus.exu_addr = a;
         bus.exu_data = d;
         sample();
         check("stream_ready", {63'd0, bus.exu_ready}, 64'd1);
         expect_write(a, d);
         step();
      end
      bus.exu_valid = 1'b0;
      step();

      // Set/clear collision on reg 7
      bus.exu_valid = 1'b1;
      bus.exu_addr = 5'd7;
      bus.exu_data = 32'h77;
      expect_write(5'd7, 32'h77);
      step();
      bus.exu_valid = 1'b0;
      bus.rsv_valid = 1'b1;
      bus.rsv_addr = 5'd7;
      sample();
      check("col_wen", {63'd0, bus.rf_wen}, 64'd1);
      step();
      bus.rsv_valid = 1'b0;
      sample();
      check("col_busy7", {32'd0, bus.busy_vec}, 64'h80);
      step();

      // Flush with both slots full and reg 4 reserved
      bus.rsv_valid = 1'b1;
      bus.rsv_addr = 5'd4;
      bus.exu_valid = 1'b1;
      bus.exu_addr = 5'd8;
      bus.exu_data = 32'h88;
      bus.lsu_valid = 1'b1;
      bus.lsu_addr = 5'd9;
      bus.lsu_data = 32'h99;
      step();
      bus.exu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.rsv_addr = 5'd10;
      bus.flush = 1'b1;
      sample();
      check("fl_wen", {63'd0, bus.rf_wen}, 64'd0);
      check("fl_exu_ready", {63'd0, bus.exu_ready}, 64'd0);
      check("fl_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
      check("fl_busy_before", {32'd0, bus.busy_vec}, 64'h90);
      step();
      bus.flush = 1'b0;
      bus.rsv_valid = 1'b0;
      sample();
      check("fl_busy_after", {32'd0, bus.busy_vec}, 64'd0);
      check("fl_wen_after", {63'd0, bus.rf_wen}, 64'd0);
      check("fl_exu_ready_after", {63'd0, bus.exu_ready}, 64'd1);
      check("fl_lsu_ready_after", {63'd0, bus.lsu_ready}, 64'd1);
      repeat (3) step();

      check("drain", {32'd0, 32'(exp_q.size())}, 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
